urv_timer_cmp: RTL and testbench

- Timer compare and interrupt stage directly downstream of the core timer.
- Consumes the 64-bit free-running tick count and the prescaler tick strobe.
- Holds a 64-bit compare value with an optional periodic auto-reload, and raises a level timer interrupt to the core.
- Software-programmable through a small single-cycle register port.

---
 rtl/urv_timer_pkg.sv | 27 ++
 rtl/urv_timer_cmp_regs.sv | 81 ++++++++
 rtl/urv_timer_cmp.sv | 125 ++++++++++++
 tb/tb_urv_timer_cmp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_timer_pkg.sv
// urv_timer_pkg: register map, bit positions and constants shared by
// the timer compare stage and its register block.
package urv_timer_pkg;

    localparam logic [2:0] ADDR_CMP_LO = 3'd0;
    localparam logic [2:0] ADDR_CMP_HI = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_PERIODIC = 2;

    localparam int STATUS_PEND = 0;
    localparam int OVR_LSB     = 8;
    localparam int OVR_WIDTH   = 8;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [OVR_WIDTH-1:0] sat_inc(
        input logic [OVR_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/urv_timer_cmp_regs.sv
// urv_timer_cmp_regs: register decode, read mux and ack; holds the
// CMP_LO shadow and PERIOD, and emits commit/rearm/W1C strobes.
module urv_timer_cmp_regs
    import urv_timer_pkg::*;
#(
    parameter int g_period_width = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [2:0]                reg_addr_i,
    input  logic                      reg_we_i,
    input  logic                      reg_re_i,
    input  logic [31:0]               reg_wdata_i,
    input  logic [63:0]               cmp_i,
    input  logic                      en_i,
    input  logic                      ie_i,
    input  logic                      periodic_i,
    input  logic                      pending_i,
    input  logic [OVR_WIDTH-1:0]      ovr_i,
    output logic [31:0]               reg_rdata_o,
    output logic                      reg_ack_o,
    output logic [31:0]               shadow_lo_o,
    output logic [g_period_width-1:0] period_o,
    output logic                      commit_o,
    output logic                      ctrl_we_o,
    output logic                      w1c_o,
    output logic                      rearm_o
);

    logic [31:0] rdata_nxt;
    logic        wr_lo;
    logic        wr_per;

    assign wr_lo     = reg_we_i & (reg_addr_i == ADDR_CMP_LO);
    assign wr_per    = reg_we_i & (reg_addr_i == ADDR_PERIOD);
    assign commit_o  = reg_we_i & (reg_addr_i == ADDR_CMP_HI);
    assign ctrl_we_o = reg_we_i & (reg_addr_i == ADDR_CTRL);
    assign w1c_o     = reg_we_i & (reg_addr_i == ADDR_STATUS)
                     & reg_wdata_i[STATUS_PEND];

    // Read mux sees pre-write state, so a combined we/re returns old data.
    always_comb begin
        rdata_nxt = '0;
        case (reg_addr_i)
            ADDR_CMP_LO: rdata_nxt = cmp_i[31:0];
            ADDR_CMP_HI: rdata_nxt = cmp_i[63:32];
            ADDR_PERIOD: rdata_nxt = 32'(period_o);
            ADDR_CTRL: begin
                rdata_nxt[CTRL_EN]       = en_i;
                rdata_nxt[CTRL_IE]       = ie_i;
                rdata_nxt[CTRL_PERIODIC] = periodic_i;
            end
            ADDR_STATUS: begin
                rdata_nxt[STATUS_PEND]            = pending_i;
                rdata_nxt[OVR_LSB +: OVR_WIDTH]   = ovr_i;
            end
            default: rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_rdata_o <= '0;
            reg_ack_o   <= 1'b0;
            shadow_lo_o <= '0;
            period_o    <= '0;
            rearm_o     <= 1'b0;
        end else begin
            reg_ack_o <= reg_we_i | reg_re_i;
            if (reg_we_i | reg_re_i)
                reg_rdata_o <= rdata_nxt;
            if (wr_lo)
                shadow_lo_o <= reg_wdata_i;
            if (wr_per)
                period_o <= reg_wdata_i[g_period_width-1:0];
            rearm_o <= commit_o
                     | (ctrl_we_o & reg_wdata_i[CTRL_EN] & ~en_i);
        end
    end

endmodule

// File: rtl/urv_timer_cmp.sv
// urv_timer_cmp: 64-bit compare with optional periodic reload and level
// interrupt. URV_TIMER_CMP_OVERRUN_EN adds a saturating overrun counter.
module urv_timer_cmp
    import urv_timer_pkg::*;
#(
    parameter int g_period_width = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] time_i,
    input  logic        tick_i,
    input  logic [2:0]  reg_addr_i,
    input  logic        reg_we_i,
    input  logic        reg_re_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic        reg_ack_o,
    output logic        irq_o
);

    logic [63:0]               cmp, cmp_nxt;
    logic                      en, en_nxt;
    logic                      ie, ie_nxt;
    logic                      per, per_nxt;
    logic                      pend, pend_nxt;
    logic                      tick_d;
    logic [OVR_WIDTH-1:0]      ovr;
    logic [31:0]               shadow_lo;
    logic [g_period_width-1:0] period;
    logic                      commit, ctrl_we, w1c, rearm;
    logic                      hit, reload;

    urv_timer_cmp_regs #(
        .g_period_width(g_period_width)
    ) u_regs (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .reg_addr_i (reg_addr_i),
        .reg_we_i   (reg_we_i),
        .reg_re_i   (reg_re_i),
        .reg_wdata_i(reg_wdata_i),
        .cmp_i      (cmp),
        .en_i       (en),
        .ie_i       (ie),
        .periodic_i (per),
        .pending_i  (pend),
        .ovr_i      (ovr),
        .reg_rdata_o(reg_rdata_o),
        .reg_ack_o  (reg_ack_o),
        .shadow_lo_o(shadow_lo),
        .period_o   (period),
        .commit_o   (commit),
        .ctrl_we_o  (ctrl_we),
        .w1c_o      (w1c),
        .rearm_o    (rearm)
    );

    // A CMP_HI commit in the same cycle overrides the match entirely.
    assign hit    = en & (tick_d | rearm) & (time_i >= cmp) & ~commit;
    assign reload = per & (period != '0);

    always_comb begin
        cmp_nxt  = cmp;
        en_nxt   = en;
        ie_nxt   = ie;
        per_nxt  = per;
        pend_nxt = pend;
        if (commit)
            cmp_nxt = {reg_wdata_i, shadow_lo};
        else if (hit && reload)
            cmp_nxt = cmp + 64'(period);
        if (hit && !reload)
            en_nxt = 1'b0;
        if (commit || w1c)
            pend_nxt = 1'b0;
        if (hit)
            pend_nxt = 1'b1;
        if (ctrl_we) begin
            en_nxt  = reg_wdata_i[CTRL_EN];
            ie_nxt  = reg_wdata_i[CTRL_IE];
            per_nxt = reg_wdata_i[CTRL_PERIODIC];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmp    <= CMP_RESET;
            en     <= 1'b0;
            ie     <= 1'b0;
            per    <= 1'b0;
            pend   <= 1'b0;
            tick_d <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            cmp    <= cmp_nxt;
            en     <= en_nxt;
            ie     <= ie_nxt;
            per    <= per_nxt;
            pend   <= pend_nxt;
            tick_d <= tick_i;
            irq_o  <= pend_nxt & ie_nxt;
        end
    end

`ifdef URV_TIMER_CMP_OVERRUN_EN
    logic [OVR_WIDTH-1:0] ovr_base;
    logic [OVR_WIDTH-1:0] ovr_nxt;

    // Clear first, then count, so a same-cycle clear and overrun gives 1.
    always_comb begin
        ovr_base = w1c ? '0 : ovr;
        ovr_nxt  = (hit && pend) ? sat_inc(ovr_base) : ovr_base;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ovr <= '0;
        else
            ovr <= ovr_nxt;
    end
`else
    assign ovr = '0;
`endif

endmodule

// File: tb/tb_urv_timer_cmp.sv
// tb_urv_timer_cmp: directed and random stimulus against a
// transaction-level model of the compare/reload rules.
module tb_urv_timer_cmp;

    localparam int PW = 16;
    localparam logic [31:0] PMASK = 32'((64'd1 << PW) - 1);

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [63:0] time_i = '0;
    logic        tick_i = 1'b0;
    logic [2:0]  reg_addr_i = '0;
    logic        reg_we_i = 1'b0;
    logic        reg_re_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic [31:0] reg_rdata_o;
    logic        reg_ack_o;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [31:0] m_period;
    logic        m_en, m_ie, m_per, m_pend;
    int          m_ovr;
    logic [63:0] m_time = '0;

    urv_timer_cmp #(
        .g_period_width(PW)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .time_i     (time_i),
        .tick_i     (tick_i),
        .reg_addr_i (reg_addr_i),
        .reg_we_i   (reg_we_i),
        .reg_re_i   (reg_re_i),
        .reg_wdata_i(reg_wdata_i),
        .reg_rdata_o(reg_rdata_o),
        .reg_ack_o  (reg_ack_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_cmp = '1; m_shadow = '0; m_period = '0;
        m_en = 0; m_ie = 0; m_per = 0; m_pend = 0; m_ovr = 0;
    endfunction

    function automatic void m_match();
        if (m_pend && m_ovr < 255) m_ovr++;
        m_pend = 1'b1;
        if (m_per && m_period != 0) m_cmp = m_cmp + 64'(m_period);
        else m_en = 1'b0;
    endfunction

    function automatic void m_eval();
        if (m_en && m_time >= m_cmp) m_match();
    endfunction

    function automatic void m_write(input logic [2:0] a,
                                    input logic [31:0] d);
        logic old_en;
        case (a)
            3'd0: m_shadow = d;
            3'd1: begin
                m_cmp = {d, m_shadow}; m_pend = 0; m_eval();
            end
            3'd2: m_period = d & PMASK;
            3'd3: begin
                old_en = m_en;
                m_en = d[0]; m_ie = d[1]; m_per = d[2];
                if (!old_en && m_en) m_eval();
            end
            3'd4: if (d[0]) begin m_pend = 0; m_ovr = 0; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [7:0] o;
`ifdef URV_TIMER_CMP_OVERRUN_EN
        o = 8'(m_ovr);
`else
        o = 8'd0;
`endif
        case (a)
            3'd0: return m_cmp[31:0];
            3'd1: return m_cmp[63:32];
            3'd2: return m_period;
            3'd3: return {29'd0, m_per, m_ie, m_en};
            3'd4: return {16'd0, o, 7'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk_i); #1;
        reg_we_i = 1; reg_addr_i = a; reg_wdata_i = d;
        @(posedge clk_i); #1;
        reg_we_i = 0;
        m_write(a, d);
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        logic [31:0] e;
        e = m_read(a);
        @(posedge clk_i); #1;
        reg_re_i = 1; reg_addr_i = a;
        @(posedge clk_i); #1;
        reg_re_i = 0;
        chk(tag, {31'd0, reg_ack_o, reg_rdata_o}, {31'd0, 1'b1, e});
    endtask

    task automatic tk(input logic [63:0] t);
        @(posedge clk_i); #1; tick_i = 1;
        @(posedge clk_i); #1; tick_i = 0; time_i = t;
        m_time = t; m_eval();
    endtask

    task automatic check_irq(input string tag);
        @(posedge clk_i); @(negedge clk_i);
        chk(tag, 64'(irq_o), 64'(m_pend & m_ie));
    endtask

    task automatic rd_all(input string tag);
        for (int a = 0; a < 5; a++) rd(3'(a), tag);
    endtask

    initial begin
        logic [31:0] e;
        m_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_irq", 64'(irq_o), 0);
        chk("rst_ack", 64'(reg_ack_o), 0);
        chk("rst_rdata", 64'(reg_rdata_o), 0);
        rst_n_i = 1;
        rd_all("rst_regs");

        // unmapped addresses and PERIOD width masking
        wr(3'd5, 32'hDEAD_BEEF);
        rd(3'd5, "unmap5");
        rd(3'd7, "unmap7");
        wr(3'd2, 32'hABCD_1234);
        rd(3'd2, "period_mask");

        // one-shot
        wr(3'd0, 100); wr(3'd1, 0); wr(3'd3, 3);
        tk(99);
        check_irq("os_99");
        @(posedge clk_i); #1; tick_i = 1;
        @(posedge clk_i); #1; tick_i = 0; time_i = 100;
        chk("os_irq_t1", 64'(irq_o), 0);
        @(posedge clk_i); #1;
        chk("os_irq_t2", 64'(irq_o), 1);
        m_time = 100; m_eval();
        rd(3'd3, "os_ctrl");
        rd(3'd4, "os_status");
        tk(101); tk(150);
        rd(3'd4, "os_no_second");
        wr(3'd4, 1);
        chk("os_w1c_irq", 64'(irq_o), 0);

        // periodic
        tk(40);
        wr(3'd0, 50); wr(3'd1, 0); wr(3'd2, 10); wr(3'd3, 7);
        for (int t = 45; t <= 80; t += 5) begin
            tk(64'(t));
            check_irq("per_irq");
            if (m_pend) begin
                rd(3'd0, "per_cmp");
                wr(3'd4, 1);
                chk("per_w1c_irq", 64'(irq_o), 0);
            end
        end

        // atomic commit through the shadow
        wr(3'd3, 0); tk(200);
        wr(3'd0, 1000); wr(3'd1, 0); wr(3'd3, 3);
        wr(3'd0, 150);
        rd(3'd0, "atom_lo_live");
        rd(3'd4, "atom_nopend");
        wr(3'd1, 0);
        check_irq("atom_rearm_irq");
        rd(3'd4, "atom_pend");
        rd(3'd0, "atom_cmp");

        // 64-bit wrap on reload
        wr(3'd3, 0); wr(3'd4, 1); wr(3'd2, 32);
        wr(3'd0, 32'hFFFF_FFF0); wr(3'd1, 32'hFFFF_FFFF);
        tk(64'hFFFF_FFFF_FFFF_FFF0);
        wr(3'd3, 7);
        rd(3'd0, "wrap_lo");
        rd(3'd1, "wrap_hi");

        // simultaneous W1C and match
        wr(3'd3, 0); wr(3'd4, 1); tk(500);
        wr(3'd0, 510); wr(3'd1, 0); wr(3'd2, 5); wr(3'd3, 7);
        tk(510);
        @(posedge clk_i); #1; tick_i = 1;
        @(posedge clk_i); #1; tick_i = 0; time_i = 515;
        reg_we_i = 1; reg_addr_i = 3'd4; reg_wdata_i = 1;
        @(posedge clk_i); #1; reg_we_i = 0;
        m_time = 515; m_ovr = 0;
        if (m_en && m_time >= m_cmp) m_match(); else m_pend = 0;
        rd(3'd4, "sim_w1c");

        // simultaneous CMP_HI commit and match
        wr(3'd0, 1000);
        @(posedge clk_i); #1; tick_i = 1;
        @(posedge clk_i); #1; tick_i = 0; time_i = 520;
        reg_we_i = 1; reg_addr_i = 3'd1; reg_wdata_i = 0;
        @(posedge clk_i); #1; reg_we_i = 0;
        m_time = 520; m_cmp = {32'd0, m_shadow}; m_pend = 0; m_eval();
        rd(3'd4, "sim_commit_pend");
        rd(3'd0, "sim_commit_cmp");

        // combined write and read returns the old value
        e = m_read(3'd2);
        @(posedge clk_i); #1;
        reg_we_i = 1; reg_re_i = 1; reg_addr_i = 3'd2; reg_wdata_i = 7;
        @(posedge clk_i); #1;
        reg_we_i = 0; reg_re_i = 0;
        chk("we_re_old", 64'(reg_rdata_o), 64'(e));
        m_write(3'd2, 7);
        rd(3'd2, "we_re_new");

        // overrun: 300 matches without clearing
        wr(3'd3, 0); wr(3'd4, 1); wr(3'd2, 1);
        wr(3'd0, 600); wr(3'd1, 0); tk(599); wr(3'd3, 5);
        for (int i = 0; i < 300; i++) tk(64'(600 + i));
        rd(3'd4, "ovr_sat");
        wr(3'd4, 1);
        rd(3'd4, "ovr_clr");

        // randomized mix
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0: tk(m_time + 64'($urandom_range(0, 12)));
                1: wr(3'd0, m_time[31:0]
                       + 32'($urandom_range(0, 60)) - 32'd10);
                2: wr(3'd1, m_time[63:32]);
                3: wr(3'd2, ($urandom_range(0, 3) == 0)
                       ? $urandom : 32'($urandom_range(0, 9)));
                4: wr(3'd3, 32'($urandom_range(0, 7)));
                default: wr(3'd4, 32'($urandom_range(0, 1)));
            endcase
            check_irq("rnd_irq");
            rd(3'($urandom_range(0, 7)), "rnd_rd");
        end

        // reset mid-operation
        wr(3'd3, 0); wr(3'd4, 1);
        wr(3'd0, 0); wr(3'd1, 0); wr(3'd3, 3);
        check_irq("pre_rst_irq");
        rd(3'd3, "pre_rst_ctrl");
        @(negedge clk_i);
        rst_n_i = 0;
        #1;
        chk("mid_rst_irq", 64'(irq_o), 0);
        chk("mid_rst_rdata", 64'(reg_rdata_o), 0);
        chk("mid_rst_ack", 64'(reg_ack_o), 0);
        @(posedge clk_i); #1;
        rst_n_i = 1;
        m_reset();
        rd_all("post_rst");
        check_irq("post_rst_irq");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
